// File: rtl/uib_stream_bridge_if.sv
// uib_stream_bridge_if: byte-stream and UIB bus signals for the stream bridge.
//   rx_*  : inbound command bytes (valid/ready)
//   tx_*  : outbound response bytes (valid/ready)
//   bus_* : single-word UIB master port
// modport master: the bridge side; modport slave: the environment side
// (UART + bus fabric).
interface uib_stream_bridge_if #(
  parameter int XLEN        = 32,
  parameter int SLAVE_WIDTH = 4
);
  logic [7:0]                  rx_data;
  logic                        rx_valid;
  logic                        rx_ready;
  logic [7:0]                  tx_data;
  logic                        tx_valid;
  logic                        tx_ready;
  logic [XLEN-1:0]             bus_dat_i;
  logic [XLEN-1:0]             bus_dat_o;
  logic [XLEN-SLAVE_WIDTH-1:0] bus_addr;
  logic [SLAVE_WIDTH-1:0]      bus_num;
  logic [2:0]                  bus_mode;
  logic                        bus_wen;
  logic                        bus_req;
  logic                        bus_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready, bus_dat_i, bus_ready,
    output rx_ready, tx_data, tx_valid, bus_dat_o, bus_addr, bus_num,
           bus_mode, bus_wen, bus_req
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, bus_dat_i, bus_ready,
    input  rx_ready, tx_data, tx_valid, bus_dat_o, bus_addr, bus_num,
           bus_mode, bus_wen, bus_req
  );
endinterface

// File: rtl/uib_stream_bridge.sv
// uib_stream_bridge: turns byte-stream commands into single-word UIB
// transactions and streams the result back.
//   'W' a3 a2 a1 a0 d3 d2 d1 d0 -> bus write, reply 'K'
//   'R' a3 a2 a1 a0             -> bus read,  reply d3 d2 d1 d0
//   other byte                  -> reply '?'
//   bus timeout                 -> reply 'T'
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bif      : uib_stream_bridge_if.master (rx bytes, tx bytes, UIB bus)
module uib_stream_bridge #(
  parameter int XLEN        = 32,
  parameter int SLAVE_WIDTH = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  uib_stream_bridge_if.master   bif
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  localparam logic [7:0] OP_W    = 8'h57;
  localparam logic [7:0] OP_R    = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            op_wr_q, op_wr_d;
  logic [XLEN-1:0] addr_q,  addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [31:0]     resp_q,  resp_d;   // response bytes, next byte in [31:24]
  logic [1:0]      cnt_q,   cnt_d;    // byte index (collect) / bytes left-1 (resp)
  logic [TW-1:0]   tmo_q,   tmo_d;

  logic rx_open, rx_acc, tx_acc;

  assign rx_open = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign rx_acc  = bif.rx_valid && rx_open;
  assign tx_acc  = (state_q == S_RESP) && bif.tx_ready;

  // rx_ready and bus_mode are forced low while rst is held so that every
  // output reads 0 across the reset edge.
  assign bif.rx_ready  = rx_open && !rst;
  assign bif.tx_valid  = (state_q == S_RESP);
  assign bif.tx_data   = resp_q[31:24];
  assign bif.bus_req   = (state_q == S_BUS);
  assign bif.bus_wen   = op_wr_q;
  assign bif.bus_dat_o = wdata_q;
  assign bif.bus_num   = addr_q[XLEN-1 -: SLAVE_WIDTH];
  assign bif.bus_addr  = addr_q[XLEN-SLAVE_WIDTH-1:0];
  assign bif.bus_mode  = rst ? 3'b000 : 3'b010;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: if (rx_acc) begin
        cnt_d = 2'd0;
        if (bif.rx_data == OP_W || bif.rx_data == OP_R) begin
          op_wr_d = (bif.rx_data == OP_W);
          state_d = S_ADDR;
        end else begin
          resp_d  = {RSP_BAD, 24'h0};
          state_d = S_RESP;
        end
      end
      S_ADDR: if (rx_acc) begin
        addr_d = {addr_q[XLEN-9:0], bif.rx_data};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          tmo_d   = '0;
          state_d = op_wr_q ? S_DATA : S_BUS;
        end
      end
      S_DATA: if (rx_acc) begin
        wdata_d = {wdata_q[XLEN-9:0], bif.rx_data};
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          tmo_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        tmo_d = tmo_q + 1'b1;
        // bus_ready takes priority over a timeout landing in the same cycle.
        if (bif.bus_ready) begin
          if (op_wr_q) begin
            resp_d = {RSP_OK, 24'h0};
            cnt_d  = 2'd0;
          end else begin
            resp_d = bif.bus_dat_i[31:0];
            cnt_d  = 2'd3;
          end
          state_d = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          resp_d  = {RSP_TMO, 24'h0};
          cnt_d   = 2'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: if (tx_acc) begin
        resp_d = {resp_q[23:0], 8'h00};
        if (cnt_q == 2'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uib_stream_bridge.sv
module tb_uib_stream_bridge;
  localparam int XLEN = 32;
  localparam int SW   = 4;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uib_stream_bridge_if #(.XLEN(XLEN), .SLAVE_WIDTH(SW)) bif ();
  uib_stream_bridge #(.XLEN(XLEN), .SLAVE_WIDTH(SW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bif(bif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory image the bench keeps of successful writes; reads of untouched
  // addresses return addr ^ A5A55A5A.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd_value(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bif.rx_data  = b;
    bif.rx_valid = 1'b1;
    while (!bif.rx_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("rx_ready_timeout", 32'(bif.rx_ready), 32'd1);
    @(posedge clk);
    #1 bif.rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(op);
    if (op == 8'h57 || op == 8'h52)
      for (int j = 3; j >= 0; j--) send_byte(addr[8*j +: 8]);
    if (op == 8'h57)
      for (int j = 3; j >= 0; j--) send_byte(wdata[8*j +: 8]);
  endtask

  // Outputs must all read 0 while rst is held after a reset edge.
  task automatic reset_check(input string tag);
    chk({tag, "_rx_ready"}, 32'(bif.rx_ready), 0);
    chk({tag, "_tx_valid"}, 32'(bif.tx_valid), 0);
    chk({tag, "_tx_data"},  32'(bif.tx_data),  0);
    chk({tag, "_bus_req"},  32'(bif.bus_req),  0);
    chk({tag, "_bus_wen"},  32'(bif.bus_wen),  0);
    chk({tag, "_bus_addr"}, 32'(bif.bus_addr), 0);
    chk({tag, "_bus_num"},  32'(bif.bus_num),  0);
    chk({tag, "_bus_dat_o"}, bif.bus_dat_o,    0);
    chk({tag, "_bus_mode"}, 32'(bif.bus_mode), 0);
  endtask

  // Full command: send bytes, act as bus slave (ready after `delay` extra
  // cycles, -1 = never), then drain the response with optional back-pressure.
  task automatic do_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input int bp, input logic [3:0] enum_,
                        input logic [27:0] ebaddr, input int rlen, input logic [31:0] eresp);
    bit   has_bus = (op == 8'h57 || op == 8'h52);
    bit   wr      = (op == 8'h57);
    int   k = 0, req_cnt = 0, exp_cnt, n;
    logic [31:0] r = eresp;
    logic [31:0] rdata = rd_value(addr);
    send_cmd(op, addr, wdata);
    @(negedge clk);
    if (has_bus) begin
      chk("req_latency", 32'(bif.bus_req), 1);
      while (bif.bus_req && k < 200) begin
        req_cnt++;
        chk("bus_num",  32'(bif.bus_num),  32'(enum_));
        chk("bus_addr", 32'(bif.bus_addr), 32'(ebaddr));
        chk("bus_wen",  32'(bif.bus_wen),  32'(wr));
        chk("bus_mode", 32'(bif.bus_mode), 32'd2);
        if (wr) chk("bus_dat_o", bif.bus_dat_o, wdata);
        if (k == delay) begin bif.bus_ready = 1'b1; bif.bus_dat_i = rdata; end
        @(posedge clk);
        #1 bif.bus_ready = 1'b0;
        bif.bus_dat_i = $urandom;
        @(negedge clk);
        k++;
      end
      exp_cnt = (delay < 0 || delay > TMO - 2) ? TMO - 1 : delay + 1;
      chk("req_cycles", 32'(req_cnt), 32'(exp_cnt));
    end else begin
      chk("no_bus_req", 32'(bif.bus_req), 0);
    end
    chk("resp_latency", 32'(bif.tx_valid), 1);
    for (int i = 0; i < rlen; i++) begin
      n = 0;
      while (!bif.tx_valid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("tx_valid_timeout", 32'(bif.tx_valid), 1);
      if (i == ((rlen > 1) ? 1 : 0)) begin
        for (int b = 0; b < bp; b++) begin
          @(posedge clk);
          @(negedge clk);
          chk("bp_tx_valid", 32'(bif.tx_valid), 1);
          chk("bp_tx_data",  32'(bif.tx_data),  32'(r[31-8*i -: 8]));
          chk("bp_rx_ready", 32'(bif.rx_ready), 0);
        end
      end
      bif.tx_ready = 1'b1;
      chk("tx_byte", 32'(bif.tx_data), 32'(r[31-8*i -: 8]));
      @(posedge clk);
      #1 bif.tx_ready = 1'b0;
      @(negedge clk);
    end
    chk("resp_done", 32'(bif.tx_valid), 0);
    chk("idle_rx_ready", 32'(bif.rx_ready), 1);
    if (wr && rlen == 1 && r[31:24] == 8'h4B) mem[addr] = wdata;
  endtask

  // Reference: what the bridge should do for a command, from the command
  // rules alone.
  task automatic model_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, input int bp);
    int rlen;
    logic [31:0] resp;
    if (op != 8'h57 && op != 8'h52)          begin rlen = 1; resp = 32'h3F00_0000; end
    else if (delay < 0 || delay > TMO - 2)   begin rlen = 1; resp = 32'h5400_0000; end
    else if (op == 8'h57)                    begin rlen = 1; resp = 32'h4B00_0000; end
    else                                     begin rlen = 4; resp = rd_value(addr); end
    do_cmd(op, addr, wdata, delay, bp, addr[31:28], addr[27:0], rlen, resp);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    int          bp;
    logic [3:0]  num;
    logic [27:0] baddr;
    int          rlen;
    logic [31:0] resp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{8'h57, 32'h0000_0100, 32'hDEAD_BEEF, 2,  0, 4'h0, 28'h000_0100, 1, 32'h4B00_0000};
    tbl[1] = '{8'h52, 32'h0000_0100, 32'h0,         0,  0, 4'h0, 28'h000_0100, 4, 32'hDEAD_BEEF};
    tbl[2] = '{8'h52, 32'h3000_0008, 32'h0,         1,  0, 4'h3, 28'h000_0008, 4, 32'h95A5_5A52};
    tbl[3] = '{8'h41, 32'h0,         32'h0,         0,  0, 4'h0, 28'h0,        1, 32'h3F00_0000};
    tbl[4] = '{8'h52, 32'h0000_0200, 32'h0,         0,  0, 4'h0, 28'h000_0200, 4, 32'hA5A5_585A};
    tbl[5] = '{8'h57, 32'h1234_5678, 32'hCAFE_F00D, -1, 0, 4'h1, 28'h234_5678, 1, 32'h5400_0000};
    tbl[6] = '{8'h52, 32'h1234_5678, 32'h0,         14, 0, 4'h1, 28'h234_5678, 4, 32'hB791_0C22};
    tbl[7] = '{8'h57, 32'hF000_0004, 32'h1122_3344, 14, 0, 4'hF, 28'h000_0004, 1, 32'h4B00_0000};
    tbl[8] = '{8'h52, 32'hF000_0004, 32'h0,         3, 10, 4'hF, 28'h000_0004, 4, 32'h1122_3344};
    tbl[9] = '{8'h52, 32'h0000_0100, 32'h0,         -1, 0, 4'h0, 28'h000_0100, 1, 32'h5400_0000};

    rst = 1'b1;
    bif.rx_data = '0; bif.rx_valid = 1'b0; bif.tx_ready = 1'b0;
    bif.bus_dat_i = '0; bif.bus_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_check("por");
    rst = 1'b0;
    @(negedge clk);
    chk("por_idle_rx_ready", 32'(bif.rx_ready), 1);

    // Directed vectors
    foreach (tbl[i])
      do_cmd(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].delay, tbl[i].bp,
             tbl[i].num, tbl[i].baddr, tbl[i].rlen, tbl[i].resp);

    // Stray bus_ready in IDLE must be ignored
    @(negedge clk);
    bif.bus_ready = 1'b1;
    @(posedge clk);
    #1 bif.bus_ready = 1'b0;
    @(negedge clk);
    chk("stray_ready_tx_valid", 32'(bif.tx_valid), 0);
    chk("stray_ready_bus_req",  32'(bif.bus_req),  0);
    chk("stray_ready_rx_ready", 32'(bif.rx_ready), 1);

    // Reset while bus_req is high: the write must be abandoned
    send_cmd(8'h57, 32'h0000_0040, 32'h0102_0304);
    @(negedge clk);
    chk("rst_bus_req_before", 32'(bif.bus_req), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_check("rst_bus");
    rst = 1'b0;
    model_cmd(8'h52, 32'h0000_0040, 32'h0, 0, 0);

    // Reset after 2 of 4 address bytes: partial address discarded
    send_byte(8'h52);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_check("rst_addr");
    rst = 1'b0;
    model_cmd(8'h52, 32'h0000_0300, 32'h0, 1, 0);

    // Randomized commands against the reference
    for (int t = 0; t < 40; t++) begin
      logic [7:0]  op;
      logic [31:0] a;
      int sel, dly;
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? 8'h57 : (sel < 8) ? 8'h52 : 8'($urandom_range(0, 255));
      a   = ($urandom_range(0, 1) == 1) ? {$urandom_range(0, 15), 28'h0} + 32'($urandom_range(0, 3) * 4)
                                        : $urandom;
      sel = $urandom_range(0, 9);
      dly = (sel == 0) ? -1 : (sel == 1) ? TMO - 2 : $urandom_range(0, 4);
      model_cmd(op, a, $urandom, dly, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
